// File: rtl/aes_pkg.sv
// Shared definitions for the AES block-chaining front end: block geometry,
// FSM state encoding and word-lane helpers.
package aes_pkg;

    localparam int unsigned AES_BLK_W     = 128;
    localparam int unsigned WORDS_PER_BLK = 4;
    localparam int unsigned WORD_W        = AES_BLK_W / WORDS_PER_BLK;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_LOAD,
        S_WAIT,
        S_DRAIN
    } aes_state_t;

    typedef logic [AES_BLK_W-1:0]               aes_blk_t;
    typedef logic [WORD_W-1:0]                  aes_word_t;
    typedef logic [$clog2(WORDS_PER_BLK)-1:0]   word_idx_t;

    localparam word_idx_t LAST_IDX = word_idx_t'(WORDS_PER_BLK - 1);

    // Word 0 is the most significant lane of the block.
    function automatic aes_word_t blk_word(input aes_blk_t blk, input word_idx_t idx);
        return blk[AES_BLK_W - 1 - WORD_W * idx -: WORD_W];
    endfunction

    function automatic aes_blk_t put_word(input aes_blk_t blk, input word_idx_t idx,
                                          input aes_word_t word);
        aes_blk_t r;
        r = blk;
        r[AES_BLK_W - 1 - WORD_W * idx -: WORD_W] = word;
        return r;
    endfunction

endpackage

// File: rtl/aes_cbc_chain.sv
// ECB/CBC chaining wrapper around an external AES core: gathers 32-bit words
// into blocks, applies the chaining XORs and streams the result back out.
module aes_cbc_chain
    import aes_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             mclk,
    input  logic             rst_n,
    input  logic             cfg_mode,
    input  logic             cfg_dir,
    input  logic [127:0]     cfg_iv,
    input  logic             iv_ld,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic             core_ld,
    output logic [127:0]     core_text_in,
    input  logic             core_done,
    input  logic [127:0]     core_text_out,
    output logic [CNT_W-1:0] blk_cnt,
    output logic             idle
);

    aes_state_t       state, state_nxt;
    word_idx_t        word_idx;
    aes_blk_t         blk_q;
    aes_blk_t         blk_nxt;
    aes_blk_t         chain_q;
    aes_blk_t         result_q;
    aes_blk_t         text_in_q;
    logic             mode_q;
    logic             dir_q;
    logic [CNT_W-1:0] blk_cnt_q;
    logic             in_acc;
    logic             out_acc;

    assign in_acc  = in_valid && in_ready;
    assign out_acc = out_valid && out_ready;
    assign blk_nxt = put_word(blk_q, word_idx, in_data);

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (in_acc) state_nxt = S_COLLECT;
            S_COLLECT: if (in_acc && word_idx == LAST_IDX) state_nxt = S_LOAD;
            S_LOAD:    state_nxt = S_WAIT;
            S_WAIT:    if (core_done) state_nxt = S_DRAIN;
            S_DRAIN:   if (out_acc && word_idx == LAST_IDX) state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // in_ready is gated by rst_n so it stays low for the whole reset pulse.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        core_ld   = 1'b0;
        idle      = 1'b0;
        out_data  = '0;
        case (state)
            S_IDLE: begin
                in_ready = rst_n;
                idle     = !iv_ld;
            end
            S_COLLECT: in_ready = rst_n;
            S_LOAD:    core_ld = 1'b1;
            S_DRAIN: begin
                out_valid = 1'b1;
                out_data  = blk_word(result_q, word_idx);
            end
            default: ;
        endcase
    end

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            word_idx  <= '0;
            blk_q     <= '0;
            chain_q   <= '0;
            result_q  <= '0;
            text_in_q <= '0;
            mode_q    <= 1'b0;
            dir_q     <= 1'b0;
            blk_cnt_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (iv_ld) begin
                        chain_q   <= cfg_iv;
                        blk_cnt_q <= '0;
                    end
                    if (in_acc) begin
                        blk_q    <= blk_nxt;
                        word_idx <= word_idx + word_idx_t'(1);
                        mode_q   <= cfg_mode;
                        dir_q    <= cfg_dir;
                    end
                end
                S_COLLECT: begin
                    if (in_acc) begin
                        blk_q    <= blk_nxt;
                        word_idx <= word_idx + word_idx_t'(1);
                        if (word_idx == LAST_IDX) begin
                            text_in_q <= (mode_q && !dir_q) ? (blk_nxt ^ chain_q) : blk_nxt;
                        end
                    end
                end
                S_WAIT: begin
                    // blk_q still holds the ciphertext needed as next decrypt chain.
                    if (core_done) begin
                        result_q <= (mode_q && dir_q) ? (core_text_out ^ chain_q) : core_text_out;
                        if (mode_q) begin
                            chain_q <= dir_q ? blk_q : core_text_out;
                        end
                    end
                end
                S_DRAIN: begin
                    if (out_acc) begin
                        word_idx <= word_idx + word_idx_t'(1);
                        if (word_idx == LAST_IDX) begin
                            blk_cnt_q <= blk_cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign core_text_in = text_in_q;
    assign blk_cnt      = blk_cnt_q;

endmodule

// File: tb/tb_aes_cbc_chain.sv
// Self-checking bench for aes_cbc_chain: known-answer vectors, drain stall,
// reset-in-flight and counter wrap, then randomized blocks against a model.
module tb_aes_cbc_chain;

    logic         mclk = 1'b0;
    logic         rst_n = 1'b0;
    logic         cfg_mode = 1'b0;
    logic         cfg_dir = 1'b0;
    logic [127:0] cfg_iv = '0;
    logic         iv_ld = 1'b0;
    logic         in_valid = 1'b0;
    logic [31:0]  in_data = '0;
    logic         out_ready = 1'b0;
    logic         core_done;
    logic [127:0] core_text_out;

    logic         in_ready, out_valid, core_ld, idle;
    logic [31:0]  out_data;
    logic [127:0] core_text_in;
    logic [15:0]  blk_cnt;

    logic         in_ready_w, out_valid_w, core_ld_w, idle_w;
    logic [31:0]  out_data_w;
    logic [127:0] core_text_in_w;
    logic [1:0]   blk_cnt_w;

    aes_cbc_chain dut (
        .mclk(mclk), .rst_n(rst_n), .cfg_mode(cfg_mode), .cfg_dir(cfg_dir),
        .cfg_iv(cfg_iv), .iv_ld(iv_ld), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .core_ld(core_ld), .core_text_in(core_text_in),
        .core_done(core_done), .core_text_out(core_text_out),
        .blk_cnt(blk_cnt), .idle(idle)
    );

    aes_cbc_chain #(.CNT_W(2)) dut_w (
        .mclk(mclk), .rst_n(rst_n), .cfg_mode(cfg_mode), .cfg_dir(cfg_dir),
        .cfg_iv(cfg_iv), .iv_ld(iv_ld), .in_valid(in_valid), .in_ready(in_ready_w),
        .in_data(in_data), .out_valid(out_valid_w), .out_ready(out_ready),
        .out_data(out_data_w), .core_ld(core_ld_w), .core_text_in(core_text_in_w),
        .core_done(core_done), .core_text_out(core_text_out),
        .blk_cnt(blk_cnt_w), .idle(idle_w)
    );

    always #5 mclk = ~mclk;

    // Stand-in AES core: known-answer pairs, otherwise an invertible scramble.
    localparam logic [127:0] SCR_K = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    logic [127:0] kt_in [3];
    logic [127:0] kt_out[3];

    function automatic logic [127:0] core_enc(input logic [127:0] x);
        for (int i = 0; i < 3; i++) if (x == kt_in[i]) return kt_out[i];
        return {x[94:0], x[127:95]} ^ SCR_K;
    endfunction

    function automatic logic [127:0] core_dec(input logic [127:0] y);
        logic [127:0] z;
        for (int i = 0; i < 3; i++) if (y == kt_out[i]) return kt_in[i];
        z = y ^ SCR_K;
        return {z[32:0], z[127:33]};
    endfunction

    int unsigned core_lat = 1;
    logic        core_dir = 1'b0;
    logic        stray_req = 1'b0;

    initial begin
        int unsigned  cnt;
        logic [127:0] res;
        cnt = 0;
        res = '0;
        core_done = 1'b0;
        core_text_out = '0;
        forever begin
            @(negedge mclk);
            core_done = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    core_done = 1'b1;
                    core_text_out = res;
                end
            end
            if (stray_req) begin
                core_done = 1'b1;
                core_text_out = {$urandom, $urandom, $urandom, $urandom};
            end
            if (core_ld) begin
                res = core_dir ? core_dec(core_text_in) : core_enc(core_text_in);
                cnt = core_lat;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int unsigned  checks = 0;
    int unsigned  errors = 0;
    logic [127:0] chain_m = '0;
    int unsigned  cnt_m = 0;

    typedef struct {
        logic         ld_iv;
        logic [127:0] iv;
        logic         mode;
        logic         dir;
        logic [127:0] blk;
        logic [127:0] exp;
    } vec_t;
    vec_t vt[5];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge mclk);
        #1;
    endtask

    task automatic load_iv(input logic [127:0] iv);
        cfg_iv = iv;
        iv_ld = 1'b1;
        #1 chk("idle_with_iv_ld", 128'(idle), 128'(0));
        tick();
        iv_ld = 1'b0;
        chain_m = iv;
        cnt_m = 0;
        chk("blk_cnt_after_iv", 128'(blk_cnt), 128'(0));
    endtask

    task automatic run_block(input logic m, input logic d, input logic [127:0] blk,
                             input logic use_tbl, input logic [127:0] tbl_exp,
                             input int unsigned lat, input int unsigned hold,
                             input logic poke_iv);
        logic [127:0] exp_core, raw, exp_out, exp;
        logic [31:0]  ew;
        int unsigned  n, stall;
        exp_core = (m && !d) ? (blk ^ chain_m) : blk;
        raw      = d ? core_dec(blk) : core_enc(exp_core);
        exp_out  = (m && d) ? (raw ^ chain_m) : raw;
        if (m) chain_m = d ? blk : raw;
        exp = use_tbl ? tbl_exp : exp_out;

        cfg_mode = m;
        cfg_dir  = d;
        core_dir = d;
        core_lat = lat;
        for (int i = 0; i < 4; i++) begin
            if (poke_iv && i == 2) begin
                cfg_iv = {$urandom, $urandom, $urandom, $urandom};
                iv_ld = 1'b1;
                tick();
                iv_ld = 1'b0;
            end
            in_data  = blk[127 - 32 * i -: 32];
            in_valid = 1'b1;
            n = 0;
            while (!in_ready && n < 50) begin
                tick();
                n++;
            end
            chk("in_ready", 128'(in_ready), 128'(1));
            tick();
            in_valid = 1'b0;
            in_data  = $urandom;
            if (i < 3) repeat ($urandom_range(0, 2)) tick();
        end
        chk("core_ld_latency", 128'(core_ld), 128'(1));
        chk("core_text_in", core_text_in, exp_core);
        n = 0;
        while (!out_valid && n < 100) begin
            tick();
            n++;
        end
        chk("out_valid_latency", 128'(n), 128'(lat + 1));
        for (int i = 0; i < 4; i++) begin
            ew = exp[127 - 32 * i -: 32];
            stall = (hold > 0 && i == 0) ? hold : $urandom_range(0, 2);
            if (hold > 0 && i == 0) begin
                in_valid = 1'b1;
                in_data  = $urandom;
            end
            for (int s = 0; s < int'(stall); s++) begin
                chk("drain_hold_data", 128'(out_data), 128'(ew));
                chk("drain_in_ready", 128'(in_ready), 128'(0));
                chk("drain_core_ld", 128'(core_ld), 128'(0));
                tick();
            end
            in_valid = 1'b0;
            chk("out_valid", 128'(out_valid), 128'(1));
            chk("out_word", 128'(out_data), 128'(ew));
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
        cnt_m++;
        chk("blk_cnt", 128'(blk_cnt), 128'(cnt_m % 65536));
        chk("blk_cnt_w2", 128'(blk_cnt_w), 128'(cnt_m % 4));
        chk("idle_after_block", 128'(idle), 128'(1));
    endtask

    initial begin
        logic [127:0] iv, pt1, pt2, ct1, ct2;
        logic         m, d, poke;

        iv  = 128'h000102030405060708090a0b0c0d0e0f;
        pt1 = 128'h6bc1bee22e409f96e93d7e117393172a;
        pt2 = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
        ct1 = 128'h7649abac8119b246cee98e9b12e9197d;
        ct2 = 128'h5086cb9b507219ee95db113a917678b2;
        kt_in[0]  = 128'h00112233445566778899aabbccddeeff;
        kt_out[0] = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        kt_in[1]  = pt1 ^ iv;
        kt_out[1] = ct1;
        kt_in[2]  = pt2 ^ ct1;
        kt_out[2] = ct2;

        vt[0] = '{1'b0, '0, 1'b0, 1'b0, 128'h00112233445566778899aabbccddeeff,
                  128'h69c4e0d86a7b0430d8cdb78070b4c55a};
        vt[1] = '{1'b1, iv, 1'b1, 1'b0, pt1, ct1};
        vt[2] = '{1'b0, '0, 1'b1, 1'b0, pt2, ct2};
        vt[3] = '{1'b1, iv, 1'b1, 1'b1, ct1, pt1};
        vt[4] = '{1'b0, '0, 1'b1, 1'b1, ct2, pt2};

        #12;
        chk("rst_in_ready", 128'(in_ready), 128'(0));
        chk("rst_idle", 128'(idle), 128'(1));
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_core_ld", 128'(core_ld), 128'(0));
        chk("rst_out_data", 128'(out_data), 128'(0));
        chk("rst_core_text_in", core_text_in, 128'(0));
        chk("rst_blk_cnt", 128'(blk_cnt), 128'(0));
        tick();
        rst_n = 1'b1;
        #1 chk("in_ready_after_rst", 128'(in_ready), 128'(1));

        for (int i = 0; i < 5; i++) begin
            if (vt[i].ld_iv) load_iv(vt[i].iv);
            run_block(vt[i].mode, vt[i].dir, vt[i].blk, 1'b1, vt[i].exp,
                      $urandom_range(1, 4), 0, 1'b0);
        end

        // CBC decrypt continuing from the last ciphertext, with a long drain stall.
        run_block(1'b1, 1'b1, {$urandom, $urandom, $urandom, $urandom}, 1'b0, '0, 2, 10, 1'b0);

        // Reset while the block is with the core; its late core_done must be ignored.
        cfg_mode = 1'b1;
        cfg_dir  = 1'b0;
        core_dir = 1'b0;
        core_lat = 8;
        for (int i = 0; i < 4; i++) begin
            in_data  = $urandom;
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_idle", 128'(idle), 128'(1));
        chk("midrst_in_ready", 128'(in_ready), 128'(0));
        chk("midrst_out_valid", 128'(out_valid), 128'(0));
        chk("midrst_core_text_in", core_text_in, 128'(0));
        chk("midrst_blk_cnt", 128'(blk_cnt), 128'(0));
        tick();
        rst_n = 1'b1;
        chain_m = '0;
        cnt_m = 0;
        stray_req = 1'b1;
        tick();
        stray_req = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk("stray_out_valid", 128'(out_valid), 128'(0));
            chk("stray_idle", 128'(idle), 128'(1));
            tick();
        end
        chk("stray_blk_cnt", 128'(blk_cnt), 128'(0));

        for (int i = 0; i < 25; i++) begin
            if (i >= 5 && $urandom_range(0, 5) == 0)
                load_iv({$urandom, $urandom, $urandom, $urandom});
            m    = ($urandom % 2) == 1;
            d    = ($urandom % 2) == 1;
            poke = ($urandom % 4) == 0;
            run_block(m, d, {$urandom, $urandom, $urandom, $urandom}, 1'b0, '0,
                      $urandom_range(1, 6), 0, poke);
            if (i == 4) chk("cnt_wrap_5_blocks", 128'(blk_cnt_w), 128'(1));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_cbc_chain.md
AES_CBC_CHAIN -- requirements
Module: aes_cbc_chain

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the processed-block counter.
REQ-002 SHALL have port mclk, input, 1, single clock; all logic on rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port cfg_mode, input, 1: 0=ECB, 1=CBC; sampled only in S_IDLE.
REQ-005 SHALL have port cfg_dir, input, 1: 0=encrypt, 1=decrypt; sampled only in S_IDLE.
REQ-006 SHALL have ports cfg_iv, input, 128, initial vector; and iv_ld, input, 1, pulse loading cfg_iv into chain register.
REQ-007 SHALL have ports in_valid, input, 1; in_ready, output, 1; in_data, input, 32: input word stream.
REQ-008 SHALL have ports out_valid, output, 1; out_ready, input, 1; out_data, output, 32: output word stream.
REQ-009 SHALL have ports core_ld, output, 1; core_text_in, output, 128; core_done, input, 1; core_text_out, input, 128: AES core handshake.
REQ-010 SHALL have ports blk_cnt, output, CNT_W, blocks completed; and idle, output, 1.

Function
REQ-011 SHALL assemble 4 accepted input words into a 128-bit block, first word into bits [127:96], last into [31:0].
REQ-012 SHALL accept an input word when in_valid && in_ready; in_ready=1 only in S_IDLE/S_COLLECT.
REQ-013 SHALL implement states S_IDLE, S_COLLECT, S_LOAD, S_WAIT, S_DRAIN.
REQ-014 SHALL transition S_IDLE->S_COLLECT on first accepted word; S_COLLECT->S_LOAD on 4th accepted word.
REQ-015 SHALL in S_LOAD assert core_ld for exactly one cycle, then go to S_WAIT.
REQ-016 SHALL drive core_text_in = block XOR chain when cfg_mode=1 and cfg_dir=0; else block unchanged; stable from S_LOAD until core_done.
REQ-017 SHALL on core_done in S_WAIT capture result: encrypt -> core_text_out; decrypt -> core_text_out XOR chain if cfg_mode=1, else core_text_out; go to S_DRAIN.
REQ-018 SHALL update chain on core_done when cfg_mode=1: encrypt -> core_text_out; decrypt -> the ciphertext block just input.
REQ-019 SHALL in S_DRAIN present result words MSW first; advance on out_valid && out_ready; after 4th word go to S_IDLE and increment blk_cnt.
REQ-020 SHALL hold out_data stable while out_valid=1 and out_ready=0.
REQ-021 SHALL wrap blk_cnt modulo 2^CNT_W.
REQ-022 SHALL ignore core_done outside S_WAIT.
REQ-023 SHALL honour iv_ld only in S_IDLE; iv_ld elsewhere ignored; iv_ld also clears blk_cnt.
REQ-024 SHALL assert idle=1 only in S_IDLE with no pending iv_ld.
REQ-025 SHALL latency: core_ld one cycle after 4th word accept; first out_valid one cycle after core_done.

Reset
REQ-026 SHALL on rst_n low asynchronously force S_IDLE, word index 0, chain=0, blk_cnt=0.
REQ-027 SHALL reset outputs: in_ready=0 during reset then 1, out_valid=0, core_ld=0, core_text_in=0, out_data=0, idle=1.
REQ-028 SHALL, on reset mid-block, discard partial/in-flight blocks; a later core_done is ignored.

Structure
REQ-029 SHALL place state encoding enum, AES_BLK_W=128, WORDS_PER_BLK=4 in shared package aes_pkg.
REQ-030 SHALL be a single module; aes_cipher_top/aes_inv_cipher_top instantiated by parent, not inside.

Verification
REQ-031 SHALL cover ECB encrypt: FIPS-197 PT 00112233445566778899aabbccddeeff, model core -> out words 69c4e0d8,6a7b0430,d8cdb780,70b4c55a.
REQ-032 SHALL cover CBC encrypt two blocks with IV 000102..0f (SP800-38A F.2.1) -> ciphertexts 7649abac8119b246cee98e9b12e9197d, 5086cb9b507219ee95db113a917678b2.
REQ-033 SHALL cover CBC decrypt of same two blocks -> original plaintexts, chain equal to last ciphertext.
REQ-034 SHALL cover out_ready held low 10 cycles in S_DRAIN -> out_data stable, in_ready=0, no core_ld.
REQ-035 SHALL cover rst_n asserted in S_WAIT, then stray core_done -> state S_IDLE, out_valid=0, blk_cnt=0.
REQ-036 SHALL cover blk_cnt wrap with CNT_W=2: 5 blocks -> blk_cnt=1.
